// File: rtl/uart_arbiter_pkg.sv
// Shared definitions for the UART arbiter: default sizes and FSM state codes.
package uart_arbiter_pkg;

  localparam int UART_ARB_NCPU    = 4;
  localparam int UART_ARB_TIMEOUT = 1024;
  localparam int UART_DATA_LEN    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr (wrapping), as both a one-hot grant and an index. Reusable for any
// N-way shared resource.
module uart_arbiter_rr #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic [SW-1:0] cand;

  // Scan candidates starting at ptr and keep the first one that requests.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + SW'(i);
      if (cand >= SW'(N)) cand = cand - SW'(N);
      if (!any && req[cand[IW-1:0]]) begin
        any                 = 1'b1;
        grant[cand[IW-1:0]] = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// N-way arbiter sharing one UART register interface among NCPU cores.
// A core locks the UART with cpu_req; its rd/wr strobes are forwarded as a
// registered one-cycle strobe and acknowledged two cycles later.
// Optional feature macro: UART_ARB_TIMEOUT_EN (forced release of an idle owner).
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int NCPU    = UART_ARB_NCPU,
  parameter int DW      = UART_DATA_LEN,
  parameter int AW      = 2,
  parameter int TIMEOUT = UART_ARB_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCPU-1:0]          cpu_req,
  input  logic [NCPU-1:0]          cpu_rd,
  input  logic [NCPU-1:0]          cpu_wr,
  input  logic [NCPU*AW-1:0]       cpu_adr,
  input  logic [NCPU*DW-1:0]       cpu_dat_o,
  output logic [NCPU*DW-1:0]       cpu_dat_i,
  output logic [NCPU-1:0]          cpu_ack,
  output logic                     uart_rd,
  output logic                     uart_wr,
  output logic [AW-1:0]            uart_addr,
  output logic [DW-1:0]            uart_din,
  input  logic [DW-1:0]            uart_dout,
  output logic [$clog2(NCPU)-1:0]  owner,
  output logic                     owner_vld,
  output logic                     timeout
);

  localparam int OW = $clog2(NCPU);

  arb_state_t    state, state_nx;
  logic [OW-1:0] ptr;
  logic          acc_is_rd;
  logic [DW-1:0] dat_q [NCPU];

  logic          own_rd, own_wr, own_req;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;

  logic            grant_en, release_en, start_acc, to_hit;
  logic [NCPU-1:0] arb_req, arb_grant;
  logic [OW-1:0]   arb_idx;
  logic            arb_any;

  assign own_rd  = cpu_rd[owner];
  assign own_wr  = cpu_wr[owner];
  assign own_req = cpu_req[owner];
  assign own_adr = cpu_adr[owner*AW +: AW];
  assign own_dat = cpu_dat_o[owner*DW +: DW];

  uart_arbiter_rr #(.N(NCPU)) u_rr (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0]   to_cnt;
  logic [NCPU-1:0] blocked;
  logic            to_fire;

  // A release while the owner still requests can only be a forced one.
  assign to_fire = release_en & own_req;
  assign to_hit  = (state == S_OWN) && (to_cnt == TW'(TIMEOUT - 1));
  assign arb_req = cpu_req & ~blocked;

  // Idle counter for the owner; restarts on a grant, any access, or outside OWN.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (grant_en || start_acc || state != S_OWN) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // A timed-out core stays excluded until it drops its request once.
  always_ff @(posedge clk) begin
    if (rst) begin
      blocked <= '0;
      timeout <= 1'b0;
    end else begin
      blocked <= (blocked & cpu_req) | (to_fire ? (NCPU'(1) << owner) : '0);
      timeout <= to_fire;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign arb_req = cpu_req;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and the control events that steer the datapath registers.
  always_comb begin
    state_nx   = state;
    grant_en   = 1'b0;
    release_en = 1'b0;
    start_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_any) begin
          grant_en = 1'b1;
          state_nx = S_OWN;
        end
      end
      S_OWN: begin
        if (own_rd || own_wr) begin
          start_acc = 1'b1;
          state_nx  = S_ACC;
        end else if (!own_req || to_hit) begin
          release_en = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      S_ACC:   state_nx = S_DONE;
      S_DONE:  state_nx = S_OWN;
      default: state_nx = S_IDLE;
    endcase
  end

  // Ownership, round-robin pointer, registered UART strobes and per-core read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      owner_vld <= 1'b0;
      ptr       <= '0;
      uart_rd   <= 1'b0;
      uart_wr   <= 1'b0;
      uart_addr <= '0;
      uart_din  <= '0;
      acc_is_rd <= 1'b0;
      for (int k = 0; k < NCPU; k++) dat_q[k] <= '0;
    end else begin
      uart_rd <= 1'b0;
      uart_wr <= 1'b0;
      if (grant_en) begin
        owner     <= arb_idx;
        owner_vld <= 1'b1;
      end
      if (release_en) begin
        owner_vld <= 1'b0;
        ptr       <= (owner == OW'(NCPU - 1)) ? '0 : owner + OW'(1);
      end
      if (start_acc) begin
        uart_wr   <= own_wr;
        uart_rd   <= own_rd & ~own_wr;
        uart_addr <= own_adr;
        uart_din  <= own_dat;
        acc_is_rd <= ~own_wr;
      end
      if (state == S_DONE) begin
        dat_q[owner] <= acc_is_rd ? uart_dout : '0;
      end
    end
  end

  // Ack and read data are combinational in DONE because uart_dout is only valid then.
  always_comb begin
    cpu_dat_i = '0;
    for (int k = 0; k < NCPU; k++) cpu_dat_i[k*DW +: DW] = dat_q[k];
    cpu_ack = '0;
    if (state == S_DONE) begin
      cpu_ack                   = NCPU'(1) << owner;
      cpu_dat_i[owner*DW +: DW] = acc_is_rd ? uart_dout : '0;
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter: a table of per-cycle vectors for the
// basic write/read/wr-wins paths, then hand sequences for round-robin order,
// stalling of non-owners, reset in the middle of an access and the timeout.
module tb_uart_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cpu_req, cpu_rd, cpu_wr;
  logic [7:0]  cpu_adr;
  logic [31:0] cpu_dat_o;
  logic [31:0] cpu_dat_i;
  logic [3:0]  cpu_ack;
  logic        uart_rd, uart_wr;
  logic [1:0]  uart_addr;
  logic [7:0]  uart_din;
  logic [7:0]  uart_dout;
  logic [1:0]  owner;
  logic        owner_vld;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  uart_arbiter #(.NCPU(4), .DW(8), .AW(2), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_adr   (cpu_adr),
    .cpu_dat_o (cpu_dat_o),
    .cpu_dat_i (cpu_dat_i),
    .cpu_ack   (cpu_ack),
    .uart_rd   (uart_rd),
    .uart_wr   (uart_wr),
    .uart_addr (uart_addr),
    .uart_din  (uart_din),
    .uart_dout (uart_dout),
    .owner     (owner),
    .owner_vld (owner_vld),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, rd, wr;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [7:0]  udout;
    logic [3:0]  ack;
    logic        urd, uwr;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [1:0]  own;
    logic        vld;
    logic [31:0] dati;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_req   = v.req;
    cpu_rd    = v.rd;
    cpu_wr    = v.wr;
    cpu_adr   = v.adr;
    cpu_dat_o = v.dat;
    uart_dout = v.udout;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cpu_req = '0; cpu_rd = '0; cpu_wr = '0;
    cpu_adr = '0; cpu_dat_o = '0; uart_dout = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic waitVld(input logic val, input string name);
    int n = 0;
    while (owner_vld !== val && n < 50) begin
      tick();
      n++;
    end
    if (owner_vld !== val) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: owner_vld stuck at %b, wanted %b", name, owner_vld, val);
    end
  endtask

  task automatic waitAck(input int k, input string name);
    int n = 0;
    while (cpu_ack === 4'b0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput(name, {28'b0, cpu_ack}, 32'(4'b0001 << k));
  endtask

  initial begin
    int order[5];
    int bad;
    int cnt;

    doReset();
    $display("[TB] reset state");
    checkOutput("rst_ack",   {28'b0, cpu_ack}, 32'h0);
    checkOutput("rst_urd",   {31'b0, uart_rd}, 32'h0);
    checkOutput("rst_uwr",   {31'b0, uart_wr}, 32'h0);
    checkOutput("rst_owner", {30'b0, owner}, 32'h0);
    checkOutput("rst_vld",   {31'b0, owner_vld}, 32'h0);
    checkOutput("rst_to",    {31'b0, timeout}, 32'h0);
    checkOutput("rst_dati",  cpu_dat_i, 32'h0);
    checkOutput("rst_addr",  {30'b0, uart_addr}, 32'h0);
    checkOutput("rst_din",   {24'b0, uart_din}, 32'h0);

    // Core 2 write then read, core 0 read, core 1 rd+wr together (wr wins).
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 32'h0};
    vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 8'h10, 32'h0041_0000, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h41, 2'd2, 1'b1, 32'h0};
    vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 8'h10, 32'h0041_0000, 8'h00, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 32'h0};
    vecs[3]  = '{4'b0100, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 32'h0};
    vecs[4]  = '{4'b0100, 4'b0100, 4'b0000, 8'h30, 32'h0,         8'h00, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h00, 2'd2, 1'b1, 32'h0};
    vecs[5]  = '{4'b0100, 4'b0100, 4'b0000, 8'h30, 32'h0,         8'hC3, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 32'h00C3_0000};
    vecs[6]  = '{4'b0100, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'hC3, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b1, 32'h00C3_0000};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 1'b0, 32'h00C3_0000};
    vecs[8]  = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 32'h00C3_0000};
    vecs[9]  = '{4'b0001, 4'b0001, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 32'h00C3_0000};
    vecs[10] = '{4'b0001, 4'b0001, 4'b0000, 8'h00, 32'h0,         8'h5A, 4'b0001, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 32'h00C3_005A};
    vecs[11] = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h5A, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 32'h00C3_005A};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 32'h00C3_005A};
    vecs[13] = '{4'b0010, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 32'h00C3_005A};
    vecs[14] = '{4'b0010, 4'b0010, 4'b0010, 8'h08, 32'h0000_7700, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h77, 2'd1, 1'b1, 32'h00C3_005A};
    vecs[15] = '{4'b0010, 4'b0010, 4'b0010, 8'h08, 32'h0000_7700, 8'hEE, 4'b0010, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 32'h00C3_005A};
    vecs[16] = '{4'b0010, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'hEE, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 32'h00C3_005A};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0,         8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 32'h00C3_005A};

    $display("[TB] vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_ack", i),   {28'b0, cpu_ack},   {28'b0, vecs[i].ack});
      checkOutput($sformatf("v%0d_urd", i),   {31'b0, uart_rd},   {31'b0, vecs[i].urd});
      checkOutput($sformatf("v%0d_uwr", i),   {31'b0, uart_wr},   {31'b0, vecs[i].uwr});
      checkOutput($sformatf("v%0d_owner", i), {30'b0, owner},     {30'b0, vecs[i].own});
      checkOutput($sformatf("v%0d_vld", i),   {31'b0, owner_vld}, {31'b0, vecs[i].vld});
      checkOutput($sformatf("v%0d_dati", i),  cpu_dat_i,          vecs[i].dati);
      checkOutput($sformatf("v%0d_to", i),    {31'b0, timeout},   32'h0);
      if (vecs[i].urd || vecs[i].uwr) begin
        checkOutput($sformatf("v%0d_addr", i), {30'b0, uart_addr}, {30'b0, vecs[i].addr});
        checkOutput($sformatf("v%0d_din", i),  {24'b0, uart_din},  {24'b0, vecs[i].din});
      end
    end

    // Round-robin: all request, each writes once and drops, then re-requests.
    $display("[TB] round-robin order");
    doReset();
    order = '{0, 1, 2, 3, 0};
    cpu_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitVld(1'b1, $sformatf("rr%0d_grant", n));
      checkOutput($sformatf("rr%0d_owner", n), {30'b0, owner}, 32'(order[n]));
      cpu_wr[order[n]] = 1'b1;
      cpu_adr   = 8'h55;
      cpu_dat_o = 32'hA0A1_A2A3;
      waitAck(order[n], $sformatf("rr%0d_ack", n));
      cpu_wr[order[n]]  = 1'b0;
      cpu_req[order[n]] = 1'b0;
      waitVld(1'b0, $sformatf("rr%0d_release", n));
      cpu_req[order[n]] = 1'b1;
    end

    // Stall: core 1 holds the lock while core 3 holds a write.
    $display("[TB] non-owner stall");
    doReset();
    cpu_req = 4'b0010;
    waitVld(1'b1, "stall_grant1");
    checkOutput("stall_owner1", {30'b0, owner}, 32'd1);
    cpu_req   = 4'b1010;
    cpu_wr    = 4'b1000;
    cpu_adr   = 8'h80;
    cpu_dat_o = 32'h9900_0000;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (cpu_ack !== 4'b0 || uart_wr !== 1'b0) bad++;
    end
    checkOutput("stall_quiet", 32'(bad), 32'd0);
    cpu_req = 4'b1000;
    waitVld(1'b0, "stall_release1");
    waitVld(1'b1, "stall_grant3");
    checkOutput("stall_owner3", {30'b0, owner}, 32'd3);
    tick();
    checkOutput("stall_uwr",  {31'b0, uart_wr},   32'd1);
    checkOutput("stall_din",  {24'b0, uart_din},  32'h99);
    checkOutput("stall_addr", {30'b0, uart_addr}, 32'd2);
    tick();
    checkOutput("stall_ack3", {28'b0, cpu_ack}, 32'h8);
    cpu_wr = 4'b0000;

    // Reset in the cycle the UART strobe is out; ptr was 2 before the reset.
    $display("[TB] reset mid-access");
    tick();
    cpu_wr    = 4'b1000;
    cpu_adr   = 8'h00;
    cpu_dat_o = 32'h1100_0000;
    tick();
    checkOutput("mid_uwr_before", {31'b0, uart_wr}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mid_uwr",   {31'b0, uart_wr},   32'd0);
    checkOutput("mid_ack",   {28'b0, cpu_ack},   32'd0);
    checkOutput("mid_vld",   {31'b0, owner_vld}, 32'd0);
    checkOutput("mid_owner", {30'b0, owner},     32'd0);
    rst     = 1'b0;
    cpu_wr  = 4'b0000;
    cpu_req = 4'b0110;
    tick();
    checkOutput("mid_regrant_vld",   {31'b0, owner_vld}, 32'd1);
    checkOutput("mid_regrant_owner", {30'b0, owner},     32'd1);

`ifdef UART_ARB_TIMEOUT_EN
    $display("[TB] forced release after idle ownership");
    doReset();
    cpu_req = 4'b0011;
    waitVld(1'b1, "to_grant0");
    checkOutput("to_owner0", {30'b0, owner}, 32'd0);
    cnt = 1;
    while (owner_vld && !timeout && cnt < 100) begin
      tick();
      if (owner_vld && !timeout) cnt++;
    end
    checkOutput("to_cycles", 32'(cnt), 32'd16);
    checkOutput("to_pulse",  {31'b0, timeout},   32'd1);
    checkOutput("to_vld",    {31'b0, owner_vld}, 32'd0);
    tick();
    checkOutput("to_pulse_end", {31'b0, timeout},   32'd0);
    checkOutput("to_next_vld",  {31'b0, owner_vld}, 32'd1);
    checkOutput("to_next_own",  {30'b0, owner},     32'd1);
`else
    $display("[TB] ownership held indefinitely");
    doReset();
    cpu_req = 4'b0001;
    waitVld(1'b1, "hold_grant0");
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (!owner_vld || timeout || owner !== 2'd0) bad++;
    end
    checkOutput("hold_no_release", 32'(bad), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
